// File: rtl/pbit_synapse_if.sv
// pbit_synapse_if: register-write, spin, start and z-issue bundle of the p-bit synapse
interface pbit_synapse_if #(
   parameter int N_SPINS = 16,
   parameter int IDX_W = 4,
   parameter int W = 32
);
   logic w_we;
   logic [IDX_W-1:0] w_addr;
   logic [W-1:0] w_data;
   logic h_we;
   logic [W-1:0] h_data;
   logic beta_we;
   logic [W-1:0] beta_data;
   logic [N_SPINS-1:0] spins;
   logic start;
   logic busy;
   logic [W-1:0] z_out;
   logic z_en;
   modport master (
      output w_we, w_addr, w_data, h_we, h_data, beta_we, beta_data, spins, start,
      input busy, z_out, z_en
   );
   modport slave (
      input w_we, w_addr, w_data, h_we, h_data, beta_we, beta_data, spins, start,
      output busy, z_out, z_en
   );
endinterface

// File: rtl/pbit_synapse.sv
// pbit_synapse: z = beta*(h + sum_j J_j*m_j), saturated and issued to the tanh unit with holdoff
module pbit_synapse #(
   parameter int N_SPINS = 16,
   parameter int IDX_W = 4,
   parameter int INT_SIZE = 8,
   parameter int FLOAT_SIZE = 24,
   parameter logic [INT_SIZE+FLOAT_SIZE-1:0] Z_LIMIT = 32'h07_000000,
   parameter int HOLDOFF = 24
) (
   input logic CLK,
   input logic RST,
   pbit_synapse_if.slave bus
);
   localparam int W = INT_SIZE + FLOAT_SIZE;
   localparam int AW = W + IDX_W + 1;
   localparam int PW = AW + W;
   localparam int CW = $clog2(HOLDOFF + 2);
   typedef enum logic [2:0] {IDLE, ACCUM, SCALE, SAT, ISSUE, HOLD} state_t;
   state_t state_q, state_d;
   logic [W-1:0] wt_q [N_SPINS];
   logic [W-1:0] wt_d [N_SPINS];
   logic [W-1:0] h_q, h_d, beta_q, beta_d, bs_q, bs_d, zn_q, zn_d, z_q, z_d;
   logic [N_SPINS-1:0] sp_q, sp_d;
   logic signed [AW-1:0] acc_q, acc_d, wx, term;
   logic signed [PW-1:0] sc_q, sc_d, prod, lim;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic en_q, en_d, busy_q, busy_d;
   assign wx = AW'(signed'(wt_q[idx_q]));
   assign term = sp_q[idx_q] ? wx : -wx;
   assign prod = PW'(acc_q) * PW'(signed'(bs_q));
   assign lim = signed'(PW'(Z_LIMIT));
   always_comb begin
      wt_d = wt_q;
      h_d = bus.h_we ? bus.h_data : h_q;
      beta_d = bus.beta_we ? bus.beta_data : beta_q;
      bs_d = bs_q;
      sp_d = sp_q;
      acc_d = acc_q;
      sc_d = sc_q;
      zn_d = zn_q;
      z_d = z_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      en_d = 1'b0;
      state_d = state_q;
      if (bus.w_we && 32'(bus.w_addr) < N_SPINS) wt_d[bus.w_addr] = bus.w_data;
      case (state_q)
         IDLE: if (bus.start) begin
            sp_d = bus.spins;
            bs_d = beta_q;
            acc_d = {{(IDX_W+1){h_q[W-1]}}, h_q};
            idx_d = '0;
            state_d = ACCUM;
         end
         ACCUM: begin
            acc_d = acc_q + term;
            idx_d = idx_q + 1'b1;
            state_d = idx_q == IDX_W'(N_SPINS - 1) ? SCALE : ACCUM;
         end
         SCALE: begin
            sc_d = prod >>> FLOAT_SIZE;
            state_d = SAT;
         end
         SAT: begin
            zn_d = sc_q > lim ? Z_LIMIT : sc_q < -lim ? -Z_LIMIT : sc_q[W-1:0];
            state_d = ISSUE;
         end
         ISSUE: begin
            z_d = zn_q;
            en_d = 1'b1;
            cnt_d = CW'(HOLDOFF);
            state_d = HOLDOFF == 0 ? IDLE : HOLD;
         end
         HOLD: begin
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q <= CW'(1) ? IDLE : HOLD;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         wt_q <= '{default: '0};
         h_q <= '0;
         beta_q <= W'(1) << FLOAT_SIZE;
         bs_q <= '0;
         sp_q <= '0;
         acc_q <= '0;
         sc_q <= '0;
         zn_q <= '0;
         z_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         en_q <= 1'b0;
         busy_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         wt_q <= wt_d;
         h_q <= h_d;
         beta_q <= beta_d;
         bs_q <= bs_d;
         sp_q <= sp_d;
         acc_q <= acc_d;
         sc_q <= sc_d;
         zn_q <= zn_d;
         z_q <= z_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         en_q <= en_d;
         busy_q <= busy_d;
         state_q <= state_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.z_out = z_q;
   assign bus.z_en = en_q;
endmodule

// File: tb/tb_pbit_synapse.sv
// tb_pbit_synapse: table-driven field vectors plus abort, ignored-start and write-hazard sequences
module tb_pbit_synapse;
   localparam int HOLDOFF = 24;
   localparam int LAT = 19;
   typedef struct {
      logic [31:0] jv;
      logic [15:0] jmask;
      logic [31:0] h;
      logic [31:0] beta;
      logic [15:0] spins;
      logic [31:0] z;
   } vec_t;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int total = 0;
   int bad = 0;
   vec_t vt [9];
   pbit_synapse_if #(.N_SPINS(16), .IDX_W(4), .W(32)) bus ();
   pbit_synapse dut (.CLK(CLK), .RST(RST), .bus(bus));
   always #5 CLK = ~CLK;
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask
   task automatic load(input vec_t v);
      for (int j = 0; j < 16; j++) begin
         bus.w_we = 1'b1;
         bus.w_addr = 4'(j);
         bus.w_data = v.jmask[j] ? v.jv : 32'h0;
         tick();
      end
      bus.w_we = 1'b0;
      bus.h_we = 1'b1;
      bus.h_data = v.h;
      bus.beta_we = 1'b1;
      bus.beta_data = v.beta;
      tick();
      bus.h_we = 1'b0;
      bus.beta_we = 1'b0;
   endtask
   task automatic finish_run(input int k0, input logic [31:0] exp_z, input string nm);
      int k = k0;
      while (!bus.z_en && k < 100) begin
         tick();
         k++;
      end
      chk({nm, "_lat"}, 64'(k), 64'(LAT));
      chk({nm, "_z"}, 64'(bus.z_out), 64'(exp_z));
      tick();
      k++;
      chk({nm, "_pulse"}, 64'(bus.z_en), 64'd0);
      while (bus.busy && k < 200) begin
         tick();
         k++;
      end
      chk({nm, "_busy"}, 64'(k), 64'(LAT + HOLDOFF));
      chk({nm, "_zhold"}, 64'(bus.z_out), 64'(exp_z));
   endtask
   task automatic run(input logic [15:0] sp, input logic [31:0] exp_z, input string nm);
      bus.spins = sp;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      finish_run(0, exp_z, nm);
   endtask
   initial begin
      int pulses;
      vt[0] = '{32'h0, 16'hFFFF, 32'h0, 32'h01_000000, 16'hFFFF, 32'h0};
      vt[1] = '{32'h00_400000, 16'hFFFF, 32'h0, 32'h01_000000, 16'hFFFF, 32'h04_000000};
      vt[2] = '{32'h00_400000, 16'hFFFF, 32'hFF_800000, 32'h01_000000, 16'hAAAA, 32'hFF_800000};
      vt[3] = '{32'h01_000000, 16'hFFFF, 32'h0, 32'h01_000000, 16'hFFFF, 32'h07_000000};
      vt[4] = '{32'h01_000000, 16'hFFFF, 32'h0, 32'h01_000000, 16'h0000, 32'hF9_000000};
      vt[5] = '{32'h01_000000, 16'h0007, 32'h0, 32'h00_800000, 16'h0007, 32'h01_800000};
      vt[6] = '{32'h00_000001, 16'h0001, 32'h0, 32'h00_800000, 16'h0000, 32'hFFFF_FFFF};
      vt[7] = '{32'h00_400000, 16'hFFFF, 32'h01_000000, 32'h02_000000, 16'h00FF, 32'h02_000000};
      vt[8] = '{32'h01_000000, 16'h000F, 32'h0, 32'h01_000000, 16'h0000, 32'hFC_000000};
      bus.w_we = 1'b0;
      bus.w_addr = '0;
      bus.w_data = '0;
      bus.h_we = 1'b0;
      bus.h_data = '0;
      bus.beta_we = 1'b0;
      bus.beta_data = '0;
      bus.spins = '0;
      bus.start = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_zen", 64'(bus.z_en), 64'd0);
      chk("rst_z", 64'(bus.z_out), 64'd0);
      run(16'hFFFF, 32'h0, "rst_run");
      for (int i = 0; i < 9; i++) begin
         load(vt[i]);
         run(vt[i].spins, vt[i].z, $sformatf("vec%0d", i));
      end
      load(vt[1]);
      bus.spins = 16'hFFFF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      bus.w_we = 1'b1;
      bus.w_addr = 4'd3;
      bus.w_data = 32'h01_400000;
      tick();
      bus.w_we = 1'b0;
      finish_run(4, 32'h04_000000, "old_w");
      run(16'hFFFF, 32'h05_000000, "new_w");
      load(vt[1]);
      bus.spins = 16'hFFFF;
      bus.start = 1'b1;
      tick();
      pulses = 0;
      for (int k = 1; k <= 80; k++) begin
         bus.start = (k == 5 || k == 30);
         tick();
         if (bus.z_en) pulses++;
      end
      bus.start = 1'b0;
      chk("ign_pulses", 64'(pulses), 64'd1);
      chk("ign_busy", 64'(bus.busy), 64'd0);
      chk("ign_z", 64'(bus.z_out), 64'h04_000000);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_z", 64'(bus.z_out), 64'd0);
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.z_en) pulses++;
      end
      chk("abort_pulses", 64'(pulses), 64'd0);
      bus.h_we = 1'b1;
      bus.h_data = 32'h00_800000;
      tick();
      bus.h_we = 1'b0;
      run(16'hFFFF, 32'h00_800000, "cleared");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pbit_synapse.md
Name: pbit_synapse

Overview:
- Upstream stage of the p-bit tanh unit: computes the local field z_i = beta * (h_i + sum_j J_ij * m_j) for one p-bit from neighbour spin states.
- Saturates the result and issues it to the tanh unit's z input with a one-cycle enable pulse.
- Holds off re-issue long enough for the tanh CORDIC and divider to finish.
- Numbers are signed fixed-point with INT_SIZE integer bits and FLOAT_SIZE fraction bits (Q8.24 by default). Spins are encoded 1 = +1, 0 = -1.

Parameters:
- N_SPINS, 16, number of neighbour spins and weights.
- IDX_W, 4, weight address width; N_SPINS <= 2**IDX_W.
- INT_SIZE, 8, integer bits of the fixed-point format.
- FLOAT_SIZE, 24, fraction bits of the fixed-point format.
- Z_LIMIT, 32'h07_000000, positive saturation bound for z (7.0).
- HOLDOFF, 24, minimum cycles from a z_en pulse until the next start is accepted.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- w_we  in  1  weight write strobe.
- w_addr  in  IDX_W  weight index j.
- w_data  in  INT_SIZE+FLOAT_SIZE  J_ij value.
- h_we  in  1  bias write strobe.
- h_data  in  INT_SIZE+FLOAT_SIZE  h_i value.
- beta_we  in  1  inverse-temperature write strobe.
- beta_data  in  INT_SIZE+FLOAT_SIZE  beta value.
- spins  in  N_SPINS  neighbour states m_j.
- start  in  1  request one field evaluation.
- busy  out  1  high from an accepted start until holdoff expires.
- z_out  out  INT_SIZE+FLOAT_SIZE  saturated field, fed to the tanh unit's z.
- z_en  out  1  one-cycle pulse; z_out is valid in the same cycle.

Behaviour:
- Reset, applied at the next CLK edge:
  - all J = 0, h = 0, beta = 32'h01_000000 (1.0).
  - z_out = 0, z_en = 0, busy = 0, state = IDLE, holdoff counter = 0.
- Register writes:
  - A write takes effect at the next edge and is allowed in any state.
  - A w_we to index j in the same cycle ACCUM reads j: ACCUM uses the old value.
  - Writes to w_addr >= N_SPINS are ignored.
- FSM states: IDLE, ACCUM, SCALE, SAT, ISSUE, HOLD.
- IDLE:
  - start=1 is accepted: snapshot spins, h and beta; acc <= sign-extended h; j <= 0; busy <= 1; go to ACCUM.
  - start while busy is ignored, with no queuing.
- ACCUM: N_SPINS cycles. Each cycle acc <= acc + (spin_snap[j] ? J[j] : -J[j]); j++. After j = N_SPINS-1, go to SCALE.
  - acc is INT_SIZE+FLOAT_SIZE+IDX_W+1 bits wide, so it never overflows.
- SCALE: prod = acc * beta_snap (signed full width); scaled = prod >>> FLOAT_SIZE (arithmetic shift, truncation toward -inf). Go to SAT.
- SAT: z_next = clamp(scaled, -Z_LIMIT, +Z_LIMIT). Go to ISSUE.
- ISSUE: z_out <= z_next; z_en <= 1 for exactly one cycle; load holdoff counter = HOLDOFF; go to HOLD.
- HOLD:
  - Counter decrements each cycle.
  - At 0: busy <= 0, go to IDLE; start is accepted from the cycle after busy falls.
  - With HOLDOFF = 0, return to IDLE directly after ISSUE.
- Latency: start sampled at edge t; z_en high during the cycle after edge t+N_SPINS+3 (19 cycles at default).
- z_out holds its value between pulses; it changes only in ISSUE.
- Spin changes after start do not affect the evaluation in flight.
- RST in any state aborts: no z_en is emitted, busy = 0 after the edge, weights are cleared.

Test Plan:
- Assert RST 2 cycles -> busy=0, z_en=0, z_out=0; start with all spins=1 and h=0 -> z_out=0 pulsed at start+19.
- J[all]=32'h00_400000 (0.25), spins=16'hFFFF, h=0, beta=1.0, start -> z_en exactly one cycle at start+19, z_out=32'h04_000000; busy deasserts HOLDOFF cycles later.
- Same J, spins=16'hAAAA, h=32'hFF_800000 (-0.5) -> z_out=32'hFF_800000.
- J[all]=1.0: spins=16'hFFFF -> z_out=32'h07_000000 (saturated); spins=16'h0000 -> z_out=32'hF9_000000.
- J[0..2]=1.0, others 0, spins=16'h0007, beta=32'h00_800000 (0.5) -> 13 spins at -1 contribute 0, z_out=32'h01_800000 (1.5). Then J[0]=32'h00_000001, other J=0, spins=0 (acc=-2^-24), beta=0.5 -> z_out=32'hFFFFFFFF (-2^-24, truncation toward -inf).
- start pulsed during ACCUM and HOLD -> ignored, only one z_en. RST in ACCUM at cycle 5 -> no z_en, busy=0 next cycle. w_we to the index being read -> old weight used.
